// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-requester memory fill arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DATA = 2'd2
    } arb_state_e;

    localparam int unsigned DEF_ADDR_WIDTH      = 16;
    localparam int unsigned DEF_DATA_WIDTH      = 40;
    localparam int unsigned DEF_BLK_OFFSET_BITS = 4;
    localparam int unsigned DEF_BEATS_PER_REQ   = 8;
    localparam int unsigned BEAT_CNT_W          = $clog2(DEF_BEATS_PER_REQ);

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker: on contention the pointer decides, otherwise the lone requester wins.
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_ptr,
    output logic       o_gnt,
    output logic       o_any
);

    always_comb begin
        o_any = |i_req;
        if (i_req == 2'b11) begin
            o_gnt = i_ptr;
        end else begin
            o_gnt = i_req[1];
        end
    end

endmodule

// File: rtl/mem_req_arb.sv
// Shares one backing-memory port between the I-cache miss handler (req0) and the
// prefetch/data fill path (req1); one block request in flight, beats routed to the grantee.
module mem_req_arb
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int unsigned BLK_OFFSET_BITS = DEF_BLK_OFFSET_BITS,
    parameter int unsigned BEATS_PER_REQ   = DEF_BEATS_PER_REQ
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  i_halt,
    input  logic [ADDR_WIDTH-1:0] i_req0_addr,
    input  logic                  i_req0_valid,
    output logic                  o_req0_ready,
    output logic [DATA_WIDTH-1:0] o_rsp0_data,
    output logic                  o_rsp0_valid,
    input  logic [ADDR_WIDTH-1:0] i_req1_addr,
    input  logic                  i_req1_valid,
    output logic                  o_req1_ready,
    output logic [DATA_WIDTH-1:0] o_rsp1_data,
    output logic                  o_rsp1_valid,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_req_valid,
    input  logic                  i_mem_ready,
    input  logic [DATA_WIDTH-1:0] i_mem_data,
    input  logic                  i_mem_data_valid,
    output logic                  o_busy,
    output logic                  o_grant
);

    localparam int unsigned CNT_W = $clog2(BEATS_PER_REQ);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS_PER_REQ - 1);

    arb_state_e            state_q, state_d;
    logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic                  rr_ptr_q, rr_ptr_d;
    logic                  grant_q, grant_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    logic                  pick_gnt;
    logic                  pick_any;
    logic [ADDR_WIDTH-1:0] pick_addr;
    logic [1:0]            req_rdy;
    logic [1:0]            rsp_vld;
    logic                  mem_req_vld;

    rr_arb2 u_rr_arb2 (
        .i_req (i_req1_valid ? {1'b1, i_req0_valid} : {1'b0, i_req0_valid}),
        .i_ptr (rr_ptr_q),
        .o_gnt (pick_gnt),
        .o_any (pick_any)
    );

    assign pick_addr = pick_gnt ? i_req1_addr : i_req0_addr;

    // Halt gates every transition and every valid/ready; o_busy still reflects the frozen state.
    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        addr_d      = addr_q;
        req_rdy     = '0;
        rsp_vld     = '0;
        mem_req_vld = 1'b0;

        if (!i_halt) begin
            unique case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        req_rdy[pick_gnt] = 1'b1;
                        grant_d = pick_gnt;
                        addr_d  = {pick_addr[ADDR_WIDTH-1:BLK_OFFSET_BITS], {BLK_OFFSET_BITS{1'b0}}};
                        state_d = ISSUE;
                    end
                end
                ISSUE: begin
                    mem_req_vld = 1'b1;
                    if (i_mem_ready) begin
                        beat_cnt_d = '0;
                        state_d    = WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (i_mem_data_valid) begin
                        rsp_vld[grant_q] = 1'b1;
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                        if (beat_cnt_q == LAST_BEAT) begin
                            rr_ptr_d = ~grant_q;
                            state_d  = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            rr_ptr_q   <= 1'b0;
            grant_q    <= 1'b0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            addr_q     <= addr_d;
        end
    end

    assign o_req0_ready    = req_rdy[0];
    assign o_req1_ready    = req_rdy[1];
    assign o_rsp0_valid    = rsp_vld[0];
    assign o_rsp1_valid    = rsp_vld[1];
    assign o_rsp0_data     = i_mem_data;
    assign o_rsp1_data     = i_mem_data;
    assign o_mem_req_valid = mem_req_vld;
    assign o_mem_addr      = addr_q;
    assign o_busy          = (state_q != IDLE);
    assign o_grant         = grant_q;

endmodule

// File: tb/tb_mem_req_arb.sv
// Directed bench for mem_req_arb: per-cycle vector table plus hand sequences for multi-cycle corners.
module tb_mem_req_arb;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        i_halt;
    logic [15:0] i_req0_addr, i_req1_addr;
    logic        i_req0_valid, i_req1_valid;
    logic        o_req0_ready, o_req1_ready;
    logic [39:0] o_rsp0_data, o_rsp1_data;
    logic        o_rsp0_valid, o_rsp1_valid;
    logic [15:0] o_mem_addr;
    logic        o_mem_req_valid;
    logic        i_mem_ready;
    logic [39:0] i_mem_data;
    logic        i_mem_data_valid;
    logic        o_busy, o_grant;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    mem_req_arb #(
        .ADDR_WIDTH      (16),
        .DATA_WIDTH      (40),
        .BLK_OFFSET_BITS (4),
        .BEATS_PER_REQ   (8)
    ) dut (
        .clk              (clk),
        .arst_n           (arst_n),
        .i_halt           (i_halt),
        .i_req0_addr      (i_req0_addr),
        .i_req0_valid     (i_req0_valid),
        .o_req0_ready     (o_req0_ready),
        .o_rsp0_data      (o_rsp0_data),
        .o_rsp0_valid     (o_rsp0_valid),
        .i_req1_addr      (i_req1_addr),
        .i_req1_valid     (i_req1_valid),
        .o_req1_ready     (o_req1_ready),
        .o_rsp1_data      (o_rsp1_data),
        .o_rsp1_valid     (o_rsp1_valid),
        .o_mem_addr       (o_mem_addr),
        .o_mem_req_valid  (o_mem_req_valid),
        .i_mem_ready      (i_mem_ready),
        .i_mem_data       (i_mem_data),
        .i_mem_data_valid (i_mem_data_valid),
        .o_busy           (o_busy),
        .o_grant          (o_grant)
    );

    // ctl = {req0_v, req1_v, halt, mem_ready, mem_dv}
    // exp = {rdy0, rdy1, mem_req_v, rsp0_v, rsp1_v, busy, grant}
    typedef struct {
        logic [4:0]  ctl;
        logic [15:0] r0a;
        logic [15:0] r1a;
        logic [39:0] md;
        logic [6:0]  exp;
        logic [15:0] ema;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [4:0] ctl, input logic [15:0] r0a,
                                input logic [15:0] r1a, input logic [39:0] md,
                                input logic [6:0] exp, input logic [15:0] ema);
        vec_t v;
        v.ctl = ctl; v.r0a = r0a; v.r1a = r1a; v.md = md; v.exp = exp; v.ema = ema;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        i_halt = 0; i_req0_valid = 0; i_req1_valid = 0;
        i_req0_addr = '0; i_req1_addr = '0;
        i_mem_ready = 0; i_mem_data = '0; i_mem_data_valid = 0;
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        clr_inputs();
        cyc();
        cyc();
        arst_n = 1'b1;
    endtask

    // Starts in an IDLE cycle before its negedge; returns just after the edge that ends the last beat.
    task automatic xfer(input logic eg, input logic [15:0] eaddr, input int unsigned halt_n,
                        input bit drop, input bit r1_on_last);
        logic [39:0] d;
        @(negedge clk);
        chk("xfer_idle_busy", o_busy, 0);
        chk("xfer_rdy0", o_req0_ready, !eg);
        chk("xfer_rdy1", o_req1_ready, eg);
        cyc();
        if (drop) begin
            if (eg) i_req1_valid = 0;
            else    i_req0_valid = 0;
        end
        i_mem_ready = 1;
        for (int unsigned h = 0; h < halt_n; h++) begin
            i_halt = 1;
            @(negedge clk);
            chk("halt_mreqv", o_mem_req_valid, 0);
            chk("halt_busy", o_busy, 1);
            cyc();
        end
        i_halt = 0;
        @(negedge clk);
        chk("issue_mreqv", o_mem_req_valid, 1);
        chk("issue_addr", o_mem_addr, eaddr);
        chk("issue_grant", o_grant, eg);
        cyc();
        i_mem_ready = 0;
        for (int unsigned b = 0; b < 8; b++) begin
            d = 40'(b + 1) + (eg ? 40'h100 : 40'h0);
            i_mem_data_valid = 1;
            i_mem_data = d;
            if (b == 7 && r1_on_last) i_req1_valid = 1;
            @(negedge clk);
            chk("beat_rsp0v", o_rsp0_valid, !eg);
            chk("beat_rsp1v", o_rsp1_valid, eg);
            chk("beat_data", eg ? o_rsp1_data : o_rsp0_data, d);
            if (b == 7 && r1_on_last) chk("lastbeat_rdy1", o_req1_ready, 0);
            cyc();
        end
        i_mem_data_valid = 0;
    endtask

    initial begin
        // Single req0 transfer with stray beats, then a req1 transfer, then halt-in-IDLE.
        tbl.push_back(mk(5'b00001, 16'h0,    16'h0,    40'h99, 7'b0000000, 16'h0));
        tbl.push_back(mk(5'b10000, 16'h4A35, 16'h0,    40'h0,  7'b1000000, 16'h0));
        tbl.push_back(mk(5'b00001, 16'h0,    16'h0,    40'h77, 7'b0010010, 16'h4A30));
        tbl.push_back(mk(5'b00000, 16'h0,    16'h0,    40'h0,  7'b0010010, 16'h4A30));
        tbl.push_back(mk(5'b00010, 16'h0,    16'h0,    40'h0,  7'b0010010, 16'h4A30));
        for (int k = 1; k <= 4; k++)
            tbl.push_back(mk(5'b00001, 16'h0, 16'h0, 40'(k), 7'b0001010, 16'h4A30));
        tbl.push_back(mk(5'b00000, 16'h0,    16'h0,    40'h0,  7'b0000010, 16'h4A30));
        for (int k = 5; k <= 8; k++)
            tbl.push_back(mk(5'b00001, 16'h0, 16'h0, 40'(k), 7'b0001010, 16'h4A30));
        tbl.push_back(mk(5'b00000, 16'h0,    16'h0,    40'h0,  7'b0000000, 16'h4A30));
        tbl.push_back(mk(5'b01000, 16'h0,    16'h8FFF, 40'h0,  7'b0100000, 16'h4A30));
        tbl.push_back(mk(5'b00010, 16'h0,    16'h0,    40'h0,  7'b0010011, 16'h8FF0));
        for (int k = 1; k <= 8; k++)
            tbl.push_back(mk(5'b00001, 16'h0, 16'h0, 40'hAA_0000_0000 + 40'(k), 7'b0000111, 16'h8FF0));
        tbl.push_back(mk(5'b00000, 16'h0,    16'h0,    40'h0,  7'b0000001, 16'h8FF0));
        tbl.push_back(mk(5'b10100, 16'h1111, 16'h0,    40'h0,  7'b0000001, 16'h8FF0));
        tbl.push_back(mk(5'b10000, 16'h1111, 16'h0,    40'h0,  7'b1000001, 16'h8FF0));
        tbl.push_back(mk(5'b00000, 16'h0,    16'h0,    40'h0,  7'b0010010, 16'h1110));

        arst_n = 1'b0;
        clr_inputs();
        #1;
        chk("rst_async_busy", o_busy, 0);
        cyc();
        cyc();
        chk("rst_outs", {o_req0_ready, o_req1_ready, o_mem_req_valid, o_rsp0_valid,
                         o_rsp1_valid, o_busy, o_grant}, 0);
        chk("rst_addr", o_mem_addr, 0);
        arst_n = 1'b1;

        foreach (tbl[i]) begin
            {i_req0_valid, i_req1_valid, i_halt, i_mem_ready, i_mem_data_valid} = tbl[i].ctl;
            i_req0_addr = tbl[i].r0a;
            i_req1_addr = tbl[i].r1a;
            i_mem_data  = tbl[i].md;
            @(negedge clk);
            chk($sformatf("vec%0d_outs", i),
                {o_req0_ready, o_req1_ready, o_mem_req_valid, o_rsp0_valid,
                 o_rsp1_valid, o_busy, o_grant}, tbl[i].exp);
            chk($sformatf("vec%0d_addr", i), o_mem_addr, tbl[i].ema);
            if (tbl[i].exp[3]) chk($sformatf("vec%0d_d0", i), o_rsp0_data, tbl[i].md);
            if (tbl[i].exp[2]) chk($sformatf("vec%0d_d1", i), o_rsp1_data, tbl[i].md);
            cyc();
        end

        // Reset asserted during the third beat abandons the transfer.
        do_reset();
        i_req1_valid = 1; i_req1_addr = 16'h0F0F;
        @(negedge clk);
        chk("rstseq_rdy1", o_req1_ready, 1);
        cyc();
        i_req1_valid = 0;
        i_mem_ready = 1;
        cyc();
        i_mem_ready = 0;
        for (int unsigned b = 0; b < 2; b++) begin
            i_mem_data_valid = 1; i_mem_data = 40'(b + 1);
            cyc();
        end
        i_mem_data = 40'h3;
        arst_n = 1'b0;
        #1;
        chk("rstseq_outs", {o_req0_ready, o_req1_ready, o_mem_req_valid, o_rsp0_valid,
                            o_rsp1_valid, o_busy, o_grant}, 0);
        chk("rstseq_addr", o_mem_addr, 0);
        #1;
        arst_n = 1'b1;
        @(negedge clk);
        chk("rstseq_drop_beat", {o_rsp0_valid, o_rsp1_valid, o_busy}, 0);
        cyc();
        i_mem_data_valid = 0;
        i_req0_valid = 1; i_req0_addr = 16'h12A7;
        @(negedge clk);
        chk("rstseq_rdy0", o_req0_ready, 1);
        cyc();
        i_req0_valid = 0;
        @(negedge clk);
        chk("rstseq_mreqv", o_mem_req_valid, 1);
        chk("rstseq_maddr", o_mem_addr, 16'h12A0);

        // Both held valid: grants alternate starting with req0.
        do_reset();
        i_req0_valid = 1; i_req0_addr = 16'h100F;
        i_req1_valid = 1; i_req1_addr = 16'h200F;
        for (int t = 0; t < 4; t++)
            xfer(t[0], t[0] ? 16'h2000 : 16'h1000, 0, 0, 0);
        clr_inputs();

        // Halt for three cycles while memory is ready in ISSUE.
        do_reset();
        i_req0_valid = 1; i_req0_addr = 16'h3456;
        xfer(0, 16'h3450, 3, 1, 0);
        @(negedge clk);
        chk("halt_done_busy", o_busy, 0);
        cyc();

        // req1 raised on req0's last beat is accepted one cycle later.
        do_reset();
        i_req0_valid = 1; i_req0_addr = 16'h5555;
        i_req1_addr = 16'h6789;
        xfer(0, 16'h5550, 0, 1, 1);
        @(negedge clk);
        chk("late_rdy1", o_req1_ready, 1);
        chk("late_rdy0", o_req0_ready, 0);
        cyc();
        clr_inputs();
        @(negedge clk);
        chk("late_issue_addr", o_mem_addr, 16'h6780);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
